// File: rtl/rvvi_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : rvvi_packetizer
//  Description : Two-entry record store that serialises compressed RVVI
//                records onto a WORD_W-bit valid/ready stream. Unused CSR
//                slots are stripped, the final beat is zero-padded, and a
//                registered stall is raised while both entries are occupied.
//                Optional macro RVVI_PKT_HDR_EN prepends a
//                {SeqNum[15:0], TotalBeats[15:0]} header to every record.
//                WORD_W must be 16 or 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvvi_packetizer #(
    parameter int XLEN     = 64,
    parameter int MAX_CSRS = 5,
    parameter int WORD_W   = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        valid,
    input  logic [72+5*XLEN+MAX_CSRS*(XLEN+16)-1:0]     rvvi,
    output logic                                        RVVIStall,
    output logic [WORD_W-1:0]                           TData,
    output logic                                        TValid,
    input  logic                                        TReady,
    output logic                                        TLast,
    output logic [31:0]                                 DropCount
);

    // Record geometry: fixed base, then MAX_CSRS slots of (XLEN+16) bits.
    localparam int c_base_w    = 72 + 5*XLEN;
    localparam int c_slot_w    = XLEN + 16;
    localparam int c_rec_w     = c_base_w + MAX_CSRS*c_slot_w;
    localparam int c_max_beats = (c_rec_w + WORD_W - 1) / WORD_W;
    localparam int c_pad_w     = c_max_beats * WORD_W;
    localparam int c_cnt_lsb   = XLEN + 168;

    // Stream FSM encoding.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_data = 2'd1;
`ifdef RVVI_PKT_HDR_EN
    localparam logic [1:0] c_st_hdr   = 2'd2;
    localparam int         c_hdr_beats = 32 / WORD_W;
    localparam logic [1:0] c_st_first = c_st_hdr;
`else
    localparam logic [1:0] c_st_first = c_st_data;
`endif

    // ------------------------------------------------------------------
    // Record store and control state
    // ------------------------------------------------------------------
    logic [c_pad_w-1:0] r_rec   [0:1];
    logic [15:0]        r_beats [0:1];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_occ;
    logic [1:0]         r_state;
    logic [15:0]        r_k;
    logic [31:0]        r_drop;

`ifdef RVVI_PKT_HDR_EN
    logic [15:0]        r_seq;
    logic               r_hdr_idx;
    logic [31:0]        w_hdr_word;
    logic               w_hdr_last;
`endif

    // Capture-side signals
    logic [11:0]        w_csr_raw;
    logic [31:0]        w_csr_cnt;
    logic [31:0]        w_bits;
    logic [15:0]        w_beats;
    logic [c_pad_w-1:0] w_masked;

    // Handshake / occupancy signals
    logic               w_accept;
    logic               w_last_beat;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [1:0]         w_occ_next;
    logic [15:0]        w_cur_beats;
    logic [c_pad_w-1:0] w_cur_rec;

    // Clamp the CSR count and derive the record length in beats.
    always_comb begin
        w_csr_raw = rvvi[c_cnt_lsb +: 12];
        if (w_csr_raw > 12'(MAX_CSRS)) begin
            w_csr_cnt = 32'(MAX_CSRS);
        end else begin
            w_csr_cnt = {20'd0, w_csr_raw};
        end
        w_bits  = 32'(c_base_w) + w_csr_cnt * 32'(c_slot_w);
        w_beats = 16'((w_bits + 32'(WORD_W - 1)) / 32'(WORD_W));
    end

    // Zero every CSR slot beyond the clamped count; slot boundaries coincide
    // with the record length, so this also zero-pads the final beat.
    always_comb begin
        w_masked = '0;
        w_masked[c_base_w-1:0] = rvvi[c_base_w-1:0];
        for (int i = 0; i < MAX_CSRS; i++) begin
            if (32'(i) < w_csr_cnt) begin
                w_masked[c_base_w + i*c_slot_w +: c_slot_w] =
                    rvvi[c_base_w + i*c_slot_w +: c_slot_w];
            end
        end
    end

    // Handshake decode: pop on the accepted last beat, push when a slot is
    // free (or is being freed this edge), otherwise the record is dropped.
    always_comb begin
        w_cur_beats = r_beats[r_rd_ptr];
        w_cur_rec   = r_rec[r_rd_ptr];
        w_accept    = (r_state != c_st_idle) && TReady;
        w_last_beat = (r_state == c_st_data) && (r_k == (w_cur_beats - 16'd1));
        w_pop       = w_accept && w_last_beat;
        w_push      = valid && ((r_occ != 2'd2) || w_pop);
        w_drop      = valid && (r_occ == 2'd2) && !w_pop;
        w_occ_next  = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occ_next = r_occ - 2'd1;
        end
    end

`ifdef RVVI_PKT_HDR_EN
    // Header word and last-header-beat decode.
    always_comb begin
        w_hdr_word = {r_seq, w_cur_beats + 16'(c_hdr_beats)};
        w_hdr_last = (r_hdr_idx == 1'(c_hdr_beats - 1));
    end
`endif

    // Record payload store; contents are qualified by occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rec[r_wr_ptr]   <= w_masked;
            r_beats[r_wr_ptr] <= w_beats;
        end
    end

    // Pointers, occupancy, drop counter and stream FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_k      <= '0;
            r_occ    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_drop && (r_drop != 32'hFFFF_FFFF)) begin
                r_drop <= r_drop + 32'd1;
            end

            case (r_state)
                c_st_idle: begin
                    // Starting on the capture edge gives TValid one cycle
                    // after capture.
                    if (w_occ_next != 2'd0) begin
                        r_state <= c_st_first;
                        r_k     <= '0;
                    end
                end
`ifdef RVVI_PKT_HDR_EN
                c_st_hdr: begin
                    if (w_accept && w_hdr_last) begin
                        r_state <= c_st_data;
                        r_k     <= '0;
                    end
                end
`endif
                c_st_data: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            // Chain straight into the next stored record.
                            r_k     <= '0;
                            r_state <= (w_occ_next != 2'd0) ? c_st_first : c_st_idle;
                        end else begin
                            r_k <= r_k + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef RVVI_PKT_HDR_EN
    // Header beat index and per-record sequence number.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq     <= '0;
            r_hdr_idx <= 1'b0;
        end else begin
            if (r_state == c_st_hdr && w_accept) begin
                r_hdr_idx <= w_hdr_last ? 1'b0 : (r_hdr_idx + 1'b1);
            end
            if (w_pop) begin
                r_seq <= r_seq + 16'd1;
            end
        end
    end
`endif

    // Stream outputs decode from registered state only, so they hold while
    // the consumer back-pressures.
    always_comb begin
        TValid    = (r_state != c_st_idle);
        TLast     = w_last_beat;
        RVVIStall = (r_occ == 2'd2);
        DropCount = r_drop;
        TData     = '0;
        if (r_state == c_st_data) begin
            TData = w_cur_rec[32'(r_k) * WORD_W +: WORD_W];
        end
`ifdef RVVI_PKT_HDR_EN
        if (r_state == c_st_hdr) begin
            TData = w_hdr_word[32'(r_hdr_idx) * WORD_W +: WORD_W];
        end
`endif
    end

endmodule
`default_nettype wire
